// File: rtl/matvec3_arbiter.sv
// ---------------------------------------------------------------------------
// matvec3_arbiter
//
// Purpose:
//   Shares a single matvec3 engine (3x3 matrix W times 3-vector x, signed
//   WIDTH-bit inputs, OUT_WIDTH-bit saturated results) between two client
//   streams. Whole jobs are granted round-robin. The granted client's words
//   are forwarded to the engine, and the SIZE_X row results are returned to
//   that same client. The arbiter also remembers which client loaded the
//   matrix currently held by the engine, and flags reuse jobs that would
//   compute against somebody else's matrix.
//
//   A job is either "new matrix" (SIZE_W matrix words followed by SIZE_X
//   vector words) or "reuse" (SIZE_X vector words only). The kind of job is
//   taken from new_matrix_i[client] on the grant cycle. Only one job is in
//   flight at a time, and every job is followed by at least one idle cycle.
//
// Ports:
//   clk_i, reset_i        clock and synchronous active-high reset
//   input_valid_i[1:0]    per-client word valid
//   input_ready_o[1:0]    per-client word accepted
//   input_data0_i/1_i     client 0 / client 1 signed input word
//   new_matrix_i[1:0]     per-client job kind (1 = W then x, 0 = x only)
//   output_valid_o[1:0]   per-client result valid
//   output_ready_i[1:0]   per-client result accepted
//   output_data_o         shared result bus, qualified by output_valid_o
//   eng_*                 handshake and data towards / from the engine
//   reuse_err_o           sticky flag: a reuse job was issued without a
//                         valid matching matrix owner
//   job_cnt0_o/1_o        completed-job counters (only with the macro below)
//
// Configuration:
//   MATVEC_ARB_STATS_EN   when defined, adds the saturating per-client
//                         completed-job counters job_cnt0_o / job_cnt1_o.
// ---------------------------------------------------------------------------
module matvec3_arbiter #(
   parameter int WIDTH     = 14,
   parameter int OUT_WIDTH = 28,
   parameter int SIZE_X    = 3,
   parameter int SIZE_W    = 9,
   parameter int CNT_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [1:0]           input_valid_i,
   output logic [1:0]           input_ready_o,
   input  logic [WIDTH-1:0]     input_data0_i,
   input  logic [WIDTH-1:0]     input_data1_i,
   input  logic [1:0]           new_matrix_i,
   output logic [1:0]           output_valid_o,
   input  logic [1:0]           output_ready_i,
   output logic [OUT_WIDTH-1:0] output_data_o,
   output logic                 eng_input_valid_o,
   input  logic                 eng_input_ready_i,
   output logic [WIDTH-1:0]     eng_input_data_o,
   output logic                 eng_new_matrix_o,
   input  logic                 eng_output_valid_i,
   output logic                 eng_output_ready_o,
   input  logic [OUT_WIDTH-1:0] eng_output_data_i,
   output logic                 reuse_err_o
`ifdef MATVEC_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]     job_cnt0_o,
   output logic [CNT_W-1:0]     job_cnt1_o
`endif
);

   // Counter widths: the input counter must reach the full new-matrix job
   // length, the output counter only has to index the SIZE_X result rows.
   localparam int LEN_W  = $clog2(SIZE_W + SIZE_X + 1);
   localparam int OCNT_W = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;

   localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(SIZE_W + SIZE_X);
   localparam logic [LEN_W-1:0]  LEN_X    = LEN_W'(SIZE_X);
   localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(SIZE_X - 1);

   // Reject nonsensical configurations at elaboration time.
   if (WIDTH < 1 || OUT_WIDTH < 1 || SIZE_X < 1 || SIZE_W < 1 || CNT_W < 1) begin : gBadParams
      $error("matvec3_arbiter: all size parameters must be positive");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic                lastGrant_q, lastGrant_d;
   logic [LEN_W-1:0]    jobLen_q, jobLen_d;
   logic [LEN_W-1:0]    inCnt_q, inCnt_d;
   logic [OCNT_W-1:0]   outCnt_q, outCnt_d;
   logic                owner_q, owner_d;
   logic                ownerValid_q, ownerValid_d;
   logic                reuseErr_q, reuseErr_d;

   logic                winner;
   logic                inFire;
   logic                outFire;
   logic                jobDone;
   logic [LEN_W-1:0]    inCntInc;

   // Round-robin pick for the IDLE cycle. A lone requester always wins; on a
   // tie the client that was not served last goes first. Since lastGrant
   // resets to 1, client 0 wins the very first tie.
   always_comb begin
      if (input_valid_i == 2'b11) begin
         winner = ~lastGrant_q;
      end else begin
         winner = input_valid_i[1];
      end
   end

   // Handshake completions towards and from the engine. Word transfers only
   // count while feeding, result transfers only while draining, so engine
   // results that show up early simply wait with ready low.
   assign inFire   = (state_q == FEED)  & input_valid_i[grant_q] & eng_input_ready_i;
   assign outFire  = (state_q == DRAIN) & eng_output_valid_i & output_ready_i[grant_q];
   assign jobDone  = outFire & (outCnt_q == OUT_LAST);
   assign inCntInc = inCnt_q + LEN_W'(1);

   // Results are passed straight through; the bus is only meaningful while
   // the owning client's output_valid is high.
   assign output_data_o = eng_output_data_i;
   assign reuse_err_o   = reuseErr_q;

   // Next-state and handshake steering. All paths are combinational so the
   // arbiter adds no pipeline stage between a client and the engine.
   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      lastGrant_d        = lastGrant_q;
      jobLen_d           = jobLen_q;
      inCnt_d            = inCnt_q;
      outCnt_d           = outCnt_q;
      owner_d            = owner_q;
      ownerValid_d       = ownerValid_q;
      reuseErr_d         = reuseErr_q;
      input_ready_o      = 2'b00;
      output_valid_o     = 2'b00;
      eng_input_valid_o  = 1'b0;
      eng_input_data_o   = '0;
      eng_new_matrix_o   = 1'b0;
      eng_output_ready_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|input_valid_i) begin
               state_d = FEED;
               grant_d = winner;
               inCnt_d = '0;
               if (new_matrix_i[winner]) begin
                  jobLen_d     = LEN_FULL;
                  owner_d      = winner;
                  ownerValid_d = 1'b1;
               end else begin
                  jobLen_d = LEN_X;
                  if (!ownerValid_q || (owner_q != winner)) begin
                     reuseErr_d = 1'b1;
                  end
               end
            end
         end

         FEED: begin
            eng_input_valid_o      = input_valid_i[grant_q];
            eng_input_data_o       = grant_q ? input_data1_i : input_data0_i;
            eng_new_matrix_o       = new_matrix_i[grant_q];
            input_ready_o[grant_q] = eng_input_ready_i;
            if (inFire) begin
               inCnt_d = inCntInc;
               if (inCntInc == jobLen_q) begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            output_valid_o[grant_q] = eng_output_valid_i;
            eng_output_ready_o      = output_ready_i[grant_q];
            if (outFire) begin
               if (outCnt_q == OUT_LAST) begin
                  outCnt_d    = '0;
                  lastGrant_d = grant_q;
                  state_d     = IDLE;
               end else begin
                  outCnt_d = outCnt_q + OCNT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset abandons any job in flight immediately; the
   // engine is reset by the same signal so no stale words survive.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         lastGrant_q  <= 1'b1;
         jobLen_q     <= '0;
         inCnt_q      <= '0;
         outCnt_q     <= '0;
         owner_q      <= 1'b0;
         ownerValid_q <= 1'b0;
         reuseErr_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         lastGrant_q  <= lastGrant_d;
         jobLen_q     <= jobLen_d;
         inCnt_q      <= inCnt_d;
         outCnt_q     <= outCnt_d;
         owner_q      <= owner_d;
         ownerValid_q <= ownerValid_d;
         reuseErr_q   <= reuseErr_d;
      end
   end

`ifdef MATVEC_ARB_STATS_EN
   logic [CNT_W-1:0] jobCnt0_q, jobCnt0_d;
   logic [CNT_W-1:0] jobCnt1_q, jobCnt1_d;

   // Completed-job counters, bumped on the last result transfer of a job.
   // They stick at all-ones instead of wrapping so a long run never reports
   // a misleadingly small number.
   always_comb begin
      jobCnt0_d = jobCnt0_q;
      jobCnt1_d = jobCnt1_q;
      if (jobDone && !grant_q && (jobCnt0_q != '1)) begin
         jobCnt0_d = jobCnt0_q + CNT_W'(1);
      end
      if (jobDone && grant_q && (jobCnt1_q != '1)) begin
         jobCnt1_d = jobCnt1_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         jobCnt0_q <= '0;
         jobCnt1_q <= '0;
      end else begin
         jobCnt0_q <= jobCnt0_d;
         jobCnt1_q <= jobCnt1_d;
      end
   end

   assign job_cnt0_o = jobCnt0_q;
   assign job_cnt1_o = jobCnt1_q;
`else
   // Without the statistics option the job-completion strobe has no user.
   logic unusedJobDone;
   assign unusedJobDone = jobDone;
`endif

endmodule

// File: tb/tb_matvec3_arbiter.sv
// ---------------------------------------------------------------------------
// tb_matvec3_arbiter
//
// Drives two client streams into matvec3_arbiter, with a behavioural matvec3
// engine attached to the engine side. Expected row results come from a
// vector table and are queued per client when a job is driven; they are
// popped and compared whenever the arbiter hands a result to that client.
// ---------------------------------------------------------------------------
module tb_matvec3_arbiter;

   localparam int WIDTH     = 14;
   localparam int OUT_WIDTH = 28;
   localparam int LIMIT     = 1000;
`ifdef MATVEC_ARB_STATS_EN
   localparam int TB_CNT_W  = 2;
`endif

   logic                 clk = 1'b0;
   logic                 reset_i = 1'b1;
   logic [1:0]           input_valid_i = 2'b00;
   logic [1:0]           input_ready_o;
   logic [WIDTH-1:0]     input_data0_i = '0;
   logic [WIDTH-1:0]     input_data1_i = '0;
   logic [1:0]           new_matrix_i = 2'b00;
   logic [1:0]           output_valid_o;
   logic [1:0]           output_ready_i = 2'b11;
   logic [OUT_WIDTH-1:0] output_data_o;
   logic                 eng_input_valid_o;
   logic                 engInReady = 1'b1;
   logic [WIDTH-1:0]     eng_input_data_o;
   logic                 eng_new_matrix_o;
   logic                 engOutValid = 1'b0;
   logic                 eng_output_ready_o;
   logic [OUT_WIDTH-1:0] engOutData = '0;
   logic                 reuse_err_o;
`ifdef MATVEC_ARB_STATS_EN
   logic [TB_CNT_W-1:0]  job_cnt0_o;
   logic [TB_CNT_W-1:0]  job_cnt1_o;
`endif

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      int                     client;
      bit                     nm;
      logic [0:8][WIDTH-1:0]  w;
      logic [0:2][WIDTH-1:0]  x;
      logic [0:2][OUT_WIDTH-1:0] exp;
      bit                     expErr;
   } vec_t;

   vec_t vecs[8];

   logic [OUT_WIDTH-1:0] expQ0[$];
   logic [OUT_WIDTH-1:0] expQ1[$];
   int                   orderQ[$];
   int                   resCnt[2];
   int                   jobsDone[2];
   logic [1:0]           busy = 2'b00;

   // Engine model state.
   logic signed [WIDTH-1:0] engW[9];
   logic signed [WIDTH-1:0] engX[3];
   int                      engIdx = 0;
   bit                      engLoad = 1'b0;
   bit                      engStall = 1'b0;
   logic [OUT_WIDTH-1:0]    engQ[$];
   bit                      rstS = 1'b1;
   bit                      inFireS = 1'b0;
   bit                      inNmS = 1'b0;
   bit                      outFireS = 1'b0;
   logic [WIDTH-1:0]        inDataS = '0;

   always #5 clk = ~clk;

   matvec3_arbiter #(
      .WIDTH     (WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SIZE_X    (3),
      .SIZE_W    (9)
`ifdef MATVEC_ARB_STATS_EN
      ,
      .CNT_W     (TB_CNT_W)
`endif
   ) dut (
      .clk_i              (clk),
      .reset_i            (reset_i),
      .input_valid_i      (input_valid_i),
      .input_ready_o      (input_ready_o),
      .input_data0_i      (input_data0_i),
      .input_data1_i      (input_data1_i),
      .new_matrix_i       (new_matrix_i),
      .output_valid_o     (output_valid_o),
      .output_ready_i     (output_ready_i),
      .output_data_o      (output_data_o),
      .eng_input_valid_o  (eng_input_valid_o),
      .eng_input_ready_i  (engInReady),
      .eng_input_data_o   (eng_input_data_o),
      .eng_new_matrix_o   (eng_new_matrix_o),
      .eng_output_valid_i (engOutValid),
      .eng_output_ready_o (eng_output_ready_o),
      .eng_output_data_i  (engOutData),
      .reuse_err_o        (reuse_err_o)
`ifdef MATVEC_ARB_STATS_EN
      ,
      .job_cnt0_o         (job_cnt0_o),
      .job_cnt1_o         (job_cnt1_o)
`endif
   );

   function automatic void checkOutput(string name, longint act, longint exp);
      assertCount++;
      if (act != exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic int qsize(int c);
      return (c == 0) ? expQ0.size() : expQ1.size();
   endfunction

   function automatic int satCnt(int n, int w);
      int top;
      top = (1 << w) - 1;
      return (n > top) ? top : n;
   endfunction

   // Sample the engine-side handshakes half a cycle before the edge they
   // complete on, so the engine model never races the arbiter's registers.
   always @(negedge clk) begin
      rstS     = reset_i;
      inFireS  = eng_input_valid_o && engInReady;
      inDataS  = eng_input_data_o;
      inNmS    = eng_new_matrix_o;
      outFireS = engOutValid && eng_output_ready_o;
   end

   // Behavioural matvec3 engine: collects W (on new-matrix jobs) and x, then
   // queues three saturated row sums. Outputs change just after the edge.
   always @(posedge clk) begin
      #1;
      if (rstS) begin
         engIdx  = 0;
         engLoad = 1'b0;
         engQ.delete();
      end else begin
         if (outFireS && engQ.size() > 0) begin
            void'(engQ.pop_front());
         end
         if (inFireS) begin
            if (engIdx == 0) begin
               engLoad = inNmS;
            end
            if (engLoad && engIdx < 9) begin
               engW[engIdx] = inDataS;
            end else begin
               engX[engIdx - (engLoad ? 9 : 0)] = inDataS;
            end
            engIdx++;
            if (engIdx == (engLoad ? 12 : 3)) begin
               for (int r = 0; r < 3; r++) begin
                  longint s;
                  s = 0;
                  for (int c = 0; c < 3; c++) begin
                     s += longint'(engW[r*3+c]) * longint'(engX[c]);
                  end
                  if (s > 134217727) begin
                     s = 134217727;
                  end else if (s < -134217728) begin
                     s = -134217728;
                  end
                  engQ.push_back(OUT_WIDTH'(s));
               end
               engIdx = 0;
            end
         end
      end
      engOutValid = (engQ.size() > 0);
      engOutData  = (engQ.size() > 0) ? engQ[0] : '0;
      engInReady  = engStall ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Scoreboard and invariants: every result handed to a client must match
   // the head of that client's expected queue; handshakes never target both
   // clients, and never a client that is not requesting.
   always @(negedge clk) begin
      checkOutput("bothInputReady", longint'(input_ready_o == 2'b11), 0);
      checkOutput("bothOutputValid", longint'(output_valid_o == 2'b11), 0);
      checkOutput("idleClientReady", longint'(|(input_ready_o & ~busy)), 0);
      checkOutput("orphanOutputValid",
                  longint'((output_valid_o[0] && qsize(0) == 0) || (output_valid_o[1] && qsize(1) == 0)), 0);
      if (reset_i) begin
         jobsDone = '{0, 0};
         resCnt   = '{0, 0};
      end
      for (int c = 0; c < 2; c++) begin
         if (output_valid_o[c] && output_ready_i[c] && qsize(c) > 0) begin
            logic [OUT_WIDTH-1:0] e;
            e = (c == 0) ? expQ0.pop_front() : expQ1.pop_front();
            checkOutput($sformatf("result client%0d", c), longint'(output_data_o), longint'(e));
            resCnt[c]++;
            if (resCnt[c] % 3 == 0) begin
               orderQ.push_back(c);
               jobsDone[c]++;
            end
         end
      end
   end

   task automatic pushExp(input int c, input logic [0:2][OUT_WIDTH-1:0] e);
      for (int k = 0; k < 3; k++) begin
         if (c == 0) expQ0.push_back(e[k]);
         else        expQ1.push_back(e[k]);
      end
   endtask

   task automatic sendWord(input int c, input logic [WIDTH-1:0] d, input bit nm);
      int guard;
      bit acc;
      input_valid_i[c] = 1'b1;
      new_matrix_i[c]  = nm;
      if (c == 0) input_data0_i = d;
      else        input_data1_i = d;
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < LIMIT) begin
         @(negedge clk);
         acc = input_ready_o[c];
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) checkOutput($sformatf("sendTimeout client%0d", c), longint'(acc), 1);
      input_valid_i[c] = 1'b0;
   endtask

   task automatic sendJob(input int c, input bit nm,
                          input logic [0:8][WIDTH-1:0] w, input logic [0:2][WIDTH-1:0] x);
      busy[c] = 1'b1;
      if (nm) begin
         for (int k = 0; k < 9; k++) sendWord(c, w[k], nm);
      end
      for (int k = 0; k < 3; k++) sendWord(c, x[k], nm);
      busy[c] = 1'b0;
   endtask

   task automatic waitIdle(input int c);
      int guard;
      guard = 0;
      while (qsize(c) != 0 && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      if (qsize(c) != 0) checkOutput($sformatf("drainTimeout client%0d", c), qsize(c), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx);
      pushExp(vecs[idx].client, vecs[idx].exp);
      sendJob(vecs[idx].client, vecs[idx].nm, vecs[idx].w, vecs[idx].x);
      waitIdle(vecs[idx].client);
      checkOutput($sformatf("reuseErr vec%0d", idx), longint'(reuse_err_o), longint'(vecs[idx].expErr));
   endtask

`ifdef MATVEC_ARB_STATS_EN
   task automatic checkStats(input string tag);
      checkOutput({"jobCnt0 ", tag}, longint'(job_cnt0_o), satCnt(jobsDone[0], TB_CNT_W));
      checkOutput({"jobCnt1 ", tag}, longint'(job_cnt1_o), satCnt(jobsDone[1], TB_CNT_W));
   endtask
`endif

   task automatic fillVectors();
      for (int i = 0; i < 8; i++) begin
         vecs[i].w = '0;
         vecs[i].x = '0;
      end
      // Client 0 loads W = 1..9, x = 1,1,1
      vecs[0].client = 0; vecs[0].nm = 1'b1;
      for (int k = 0; k < 9; k++) vecs[0].w[k] = WIDTH'(k + 1);
      vecs[0].x   = {14'd1, 14'd1, 14'd1};
      vecs[0].exp = {28'd6, 28'd15, 28'd24};
      vecs[0].expErr = 1'b0;
      // Client 0 reuses its own matrix: column 1
      vecs[1].client = 0; vecs[1].nm = 1'b0;
      vecs[1].x   = {14'd0, 14'd1, 14'd0};
      vecs[1].exp = {28'd2, 28'd5, 28'd8};
      vecs[1].expErr = 1'b0;
      // Client 1 reuses client 0's matrix: flagged but still computed
      vecs[2].client = 1; vecs[2].nm = 1'b0;
      vecs[2].x   = {14'd2, 14'd0, 14'd0};
      vecs[2].exp = {28'd2, 28'd8, 28'd14};
      vecs[2].expErr = 1'b1;
      // Client 1 loads diag(-1, 2, -3), signed x
      vecs[3].client = 1; vecs[3].nm = 1'b1;
      vecs[3].w[0] = WIDTH'(-1); vecs[3].w[4] = WIDTH'(2); vecs[3].w[8] = WIDTH'(-3);
      vecs[3].x   = {WIDTH'(5), WIDTH'(-6), WIDTH'(7)};
      vecs[3].exp = {OUT_WIDTH'(-5), OUT_WIDTH'(-12), OUT_WIDTH'(-21)};
      vecs[3].expErr = 1'b1;
      // Client 1 reuses its own diagonal matrix
      vecs[4].client = 1; vecs[4].nm = 1'b0;
      vecs[4].x   = {14'd1, 14'd1, 14'd1};
      vecs[4].exp = {OUT_WIDTH'(-1), OUT_WIDTH'(2), OUT_WIDTH'(-3)};
      vecs[4].expErr = 1'b1;
      // Client 0 loads all -8192 with x all -8192: positive saturation
      vecs[5].client = 0; vecs[5].nm = 1'b1;
      for (int k = 0; k < 9; k++) vecs[5].w[k] = 14'h2000;
      vecs[5].x   = {14'h2000, 14'h2000, 14'h2000};
      vecs[5].exp = {28'h7FFFFFF, 28'h7FFFFFF, 28'h7FFFFFF};
      vecs[5].expErr = 1'b1;
      // Client 0 reuses with x all 8191: negative saturation
      vecs[6].client = 0; vecs[6].nm = 1'b0;
      vecs[6].x   = {14'h1FFF, 14'h1FFF, 14'h1FFF};
      vecs[6].exp = {28'h8000000, 28'h8000000, 28'h8000000};
      vecs[6].expErr = 1'b1;
      // Client 1 reuses client 0's matrix, column 0
      vecs[7].client = 1; vecs[7].nm = 1'b0;
      vecs[7].x   = {14'd1, 14'd0, 14'd0};
      vecs[7].exp = {OUT_WIDTH'(-8192), OUT_WIDTH'(-8192), OUT_WIDTH'(-8192)};
      vecs[7].expErr = 1'b1;
   endtask

   initial begin
      fillVectors();
      jobsDone = '{0, 0};
      resCnt   = '{0, 0};

      // Reset state
      reset_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstInputReady", longint'(input_ready_o), 0);
      checkOutput("rstOutputValid", longint'(output_valid_o), 0);
      checkOutput("rstEngInValid", longint'(eng_input_valid_o), 0);
      checkOutput("rstEngOutReady", longint'(eng_output_ready_o), 0);
      checkOutput("rstReuseErr", longint'(reuse_err_o), 0);
`ifdef MATVEC_ARB_STATS_EN
      checkStats("reset");
`endif
      @(posedge clk);
      #1;
      reset_i = 1'b0;

      // Simultaneous requests after reset: 0,1,0,1
      $display("[TB] tie arbitration");
      orderQ.delete();
      for (int k = 0; k < 2; k++) begin
         pushExp(0, vecs[0].exp);
         pushExp(1, vecs[0].exp);
      end
      fork
         begin
            sendJob(0, 1'b1, vecs[0].w, vecs[0].x);
            sendJob(0, 1'b1, vecs[0].w, vecs[0].x);
         end
         begin
            sendJob(1, 1'b1, vecs[0].w, vecs[0].x);
            sendJob(1, 1'b1, vecs[0].w, vecs[0].x);
         end
      join
      waitIdle(0);
      waitIdle(1);
      checkOutput("tieOrderLen", orderQ.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < orderQ.size()) checkOutput($sformatf("tieOrder%0d", i), orderQ[i], i % 2);
      end
      checkOutput("tieReuseErr", longint'(reuse_err_o), 0);
`ifdef MATVEC_ARB_STATS_EN
      checkStats("afterTie");
`endif

      // Table of jobs, with random engine input stalls
      $display("[TB] vector table");
      engStall = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(i);
      engStall = 1'b0;

      // Client 0 output back-pressure for 5 cycles in DRAIN
      $display("[TB] output back-pressure");
      output_ready_i[0] = 1'b0;
      pushExp(0, vecs[0].exp);
      fork
         sendJob(0, 1'b1, vecs[0].w, vecs[0].x);
         begin : bpCtl
            int guard;
            guard = 0;
            do begin
               @(negedge clk);
               guard++;
            end while (!output_valid_o[0] && guard < LIMIT);
            checkOutput("bpValidSeen", longint'(output_valid_o[0]), 1);
            for (int k = 0; k < 5; k++) begin
               if (k > 0) @(negedge clk);
               checkOutput("bpValidHeld", longint'(output_valid_o[0]), 1);
               checkOutput("bpEngReadyLow", longint'(eng_output_ready_o), 0);
               checkOutput("bpDataHeld", longint'(output_data_o), 6);
            end
            @(posedge clk);
            #1;
            output_ready_i[0] = 1'b1;
         end
      join
      waitIdle(0);
`ifdef MATVEC_ARB_STATS_EN
      checkStats("afterTable");
`endif

      // Reset after four words of a new-matrix job
      $display("[TB] reset mid-job");
      busy[0] = 1'b1;
      for (int k = 0; k < 4; k++) sendWord(0, vecs[0].w[k], 1'b1);
      input_valid_i[0] = 1'b1;
      input_data0_i    = vecs[0].w[4];
      reset_i          = 1'b1;
      @(posedge clk);
      #1;
      reset_i       = 1'b0;
      input_valid_i = 2'b00;
      @(negedge clk);
      checkOutput("midRstInputReady", longint'(input_ready_o), 0);
      checkOutput("midRstEngInValid", longint'(eng_input_valid_o), 0);
      checkOutput("midRstOutputValid", longint'(output_valid_o), 0);
      checkOutput("midRstReuseErr", longint'(reuse_err_o), 0);
      busy[0] = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(0);
`ifdef MATVEC_ARB_STATS_EN
      checkStats("afterMidReset");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
